ula_multiciclo: RTL and testbench
=================================

Name: ula_multiciclo

Overview:
Parametrised multi-cycle ALU, the successor to the pipeline's 64-bit combinational adder/subtractor/AND unit. Adds logic, shift and compare ops, iterative multiply and optional iterative divide, with registered results and NZCV flags. A valid/ready handshake on both sides lets the EX stage stall on long operations.

Parameters:
WIDTH, 64, operand/result width; power of two, >= 8.
SHW, $clog2(WIDTH), localparam; shift-amount width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operation request.
in_ready  out  1  unit can accept a request.
operation  in  4  opcode (see Behaviour).
operand1  in  WIDTH  A.
operand2  in  WIDTH  B.
out_valid  out  1  result/flag/err valid; held until accepted.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  registered result.
flag  out  4  [0] zero, [1] negative, [2] carry, [3] overflow.
err  out  1  unsupported opcode for this build.

Behaviour:
- Reset (async, rst=1): state IDLE; result=0, flag=0, err=0, out_valid=0, internal counter and accumulators 0. Reset mid-operation abandons the op; no result is produced.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU. Opcodes 14, 15: result=0, err=1, single-cycle.
- Shifts use operand2[SHW-1:0] only.
- Flags: zero = (result==0); negative = result[WIDTH-1]; carry = carry-out for ADD, 1 when operand1 >= operand2 (unsigned) for SUB, else 0; overflow = signed overflow for ADD/SUB, else 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready. Operands are captured at accept; later input changes are ignored.
- States:
  - IDLE: accept of a single-cycle op -> DONE next cycle with result registered (out_valid in cycle N+1). Accept of MUL/MULHU -> MUL with cnt=WIDTH; accept of DIVU/REMU -> DIV with cnt=WIDTH.
  - MUL: shift-add, one multiplier bit per cycle; cnt decrements; when cnt==1 -> DONE. out_valid in cycle N+1+WIDTH.
  - DIV: restoring division, one quotient bit per cycle, same counting and latency as MUL.
  - DONE: out_valid=1; result/flag/err stable. When out_ready=1 and no accept -> IDLE. When out_ready=1 and an accept occurs in the same cycle, the new op starts as from IDLE (back-to-back single-cycle ops sustain 1 op/cycle).
- in_valid is ignored in MUL and DIV (in_ready=0).
- Divide by zero: quotient = all ones, remainder = operand1, carry/overflow = 0, err = 0, full latency.
- Wrap-around: ADD/SUB/MUL results are truncated to WIDTH bits.

Optional Feature:
ULA_DIV_EN: when defined, DIVU/REMU are implemented as above. When undefined, no divider logic is built; opcodes 12/13 behave like 14/15 (single-cycle, result=0, flag zero=1, err=1) and state DIV does not exist.

Test Plan:
- Reset mid-MUL: accept MUL 3*5, assert rst at cycle 10 -> out_valid=0, result=0, in_ready=1 after release; no late result.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> out_valid next cycle, result 0x8000_0000_0000_0000, flag=4'b1010. SUB 5-5 -> result 0, flag=4'b0101.
- Back-to-back with out_ready=1: XOR, SRA(0x8000_0000_0000_0000, 4), SLT(-1, 1) on consecutive cycles -> results 0xF0F0 (for 0xFF00^0x0FF0), 0xF800_0000_0000_0000, 1 on consecutive cycles.
- MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> out_valid exactly 65 cycles after accept, result 1; MUL of the same operands -> 0xFFFF_FFFF_FFFF_FFFE; in_ready=0 throughout.
- Backpressure: single-cycle op completes with out_ready=0 for 5 cycles -> result/flag held and out_valid=1; in_ready=0 until out_ready=1.
- With ULA_DIV_EN: DIVU 100/7 -> 14, REMU -> 2, DIVU x/0 -> all ones. Without ULA_DIV_EN: DIVU -> result 0, err=1, one cycle.

Source files
------------

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops plus iterative shift-add multiply.
// Define ULA_DIV_EN to build the iterative restoring divider for DIVU/REMU.
module ula_multiciclo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
`ifdef ULA_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ULA_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   mul_res;

  function automatic logic [3:0] mk_flag(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {v, c, r[WIDTH-1], (r == '0)};
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign shamt     = operand2[SHW-1:0];
  assign is_mul    = (operation == OP_MUL) | (operation == OP_MULHU);
`ifdef ULA_DIV_EN
  assign is_div    = (operation == OP_DIVU) | (operation == OP_REMU);
`else
  assign is_div    = 1'b0;
`endif

  always_comb begin
    sum_ext = {1'b0, operand1} + {1'b0, operand2};
    dif_ext = {1'b0, operand1} - {1'b0, operand2};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (operation)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = ~dif_ext[WIDTH];
        alu_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_SLL:  alu_res = operand1 << shamt;
      OP_SRL:  alu_res = operand1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(operand1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      // Reserved opcodes (and divide opcodes when no divider is built) land here.
      default: alu_err = 1'b1;
    endcase
  end

  // Multiplier: acc_hi:acc_lo holds partial product over the remaining multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
    mul_res  = (op_q == OP_MULHU) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
  end

`ifdef ULA_DIV_EN
  // Divider: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mcand});
    div_rem   = div_ok ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];
    div_quo   = {acc_lo[WIDTH-2:0], div_ok};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      result <= '0;
      flag   <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      op_q <= operation;
      if (is_mul) begin
        state  <= MUL;
        cnt    <= CW'(WIDTH);
        acc_hi <= '0;
        acc_lo <= operand2;
        mcand  <= operand1;
`ifdef ULA_DIV_EN
      end else if (is_div) begin
        state  <= DIV;
        cnt    <= CW'(WIDTH);
        acc_hi <= '0;
        acc_lo <= operand1;
        mcand  <= operand2;
`endif
      end else begin
        state  <= DONE;
        result <= alu_res;
        flag   <= mk_flag(alu_res, alu_c, alu_v);
        err    <= alu_err;
      end
    end else begin
      case (state)
        MUL: begin
          acc_hi <= mul_next[2*WIDTH-1:WIDTH];
          acc_lo <= mul_next[WIDTH-1:0];
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            result <= mul_res;
            flag   <= mk_flag(mul_res, 1'b0, 1'b0);
            err    <= 1'b0;
          end
        end
`ifdef ULA_DIV_EN
        DIV: begin
          acc_hi <= div_rem;
          acc_lo <= div_quo;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            result <= (op_q == OP_REMU) ? div_rem : div_quo;
            flag   <= mk_flag((op_q == OP_REMU) ? div_rem : div_quo, 1'b0, 1'b0);
            err    <= 1'b0;
          end
        end
`endif
        DONE: if (out_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed scenarios plus random ops against an arithmetic model.
module tb_ula_multiciclo;
  localparam int W = 64;
  localparam int SH = $clog2(W);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flag;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model from the arithmetic definition of each opcode.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f, output logic e, output int lat);
    logic [2*W-1:0]   p;
    logic signed [W+1:0] s, smax, smin;
    logic c, v;
    c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; r = '0;
    smax = $signed({2'b00, 1'b0, {(W-1){1'b1}}});
    smin = $signed({2'b11, 1'b1, {(W-1){1'b0}}});
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'd0: begin
        r = a + b; c = (r < a);
        s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        v = (s > smax) || (s < smin);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        v = (s > smax) || (s < smin);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[SH-1:0];
      4'd6: r = a >> b[SH-1:0];
      4'd7: r = $unsigned($signed(a) >>> b[SH-1:0]);
      4'd8: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd9: r = (a < b) ? W'(1) : W'(0);
      4'd10: begin r = p[W-1:0];   lat = W + 1; end
      4'd11: begin r = p[2*W-1:W]; lat = W + 1; end
`ifdef ULA_DIV_EN
      4'd12: begin r = (b == 0) ? '1 : a / b; lat = W + 1; end
      4'd13: begin r = (b == 0) ? a : a % b;  lat = W + 1; end
`endif
      default: e = 1'b1;
    endcase
    f = {v, c, r[W-1], (r == '0)};
  endtask

  // Drives one op with out_ready=1 and reports what the DUT produced and how long it took.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] f, output logic e,
                        output int lat, output logic busy_ready);
    int guard;
    @(negedge clk);
    operation = op; operand1 = a; operand2 = b; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    operand1 = {$urandom, $urandom};
    operand2 = {$urandom, $urandom};
    operation = 4'($urandom_range(0, 15));
    lat = 1; busy_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    r = result; f = flag; e = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; operation = '0; operand1 = '0; operand2 = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (result !== '0) begin n_fail++; $display("[TB] FAIL reset_result got %h want 0", result); end
    n_checks++; if (flag !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flag got %b want 0000", flag); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r; logic [3:0] f; logic e, br; int lat;
    run_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, f, e, lat, br);
    n_checks++; if (r !== 64'h8000_0000_0000_0000) begin n_fail++; $display("[TB] FAIL add_ovf_result got %h want 8000000000000000", r); end
    n_checks++; if (f !== 4'b1010) begin n_fail++; $display("[TB] FAIL add_ovf_flag got %b want 1010", f); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL add_latency got %0d want 1", lat); end
    run_op(4'd1, 64'd5, 64'd5, r, f, e, lat, br);
    n_checks++; if (r !== '0) begin n_fail++; $display("[TB] FAIL sub_zero_result got %h want 0", r); end
    n_checks++; if (f !== 4'b0101) begin n_fail++; $display("[TB] FAIL sub_zero_flag got %b want 0101", f); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [3];
    logic [W-1:0] as [3];
    logic [W-1:0] bs [3];
    logic [W-1:0] ex [3];
    ops = '{4'd4, 4'd7, 4'd8};
    as  = '{64'hFF00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    bs  = '{64'h0FF0, 64'd4, 64'd1};
    ex  = '{64'hF0F0, 64'hF800_0000_0000_0000, 64'd1};
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    operation = ops[0]; operand1 = as[0]; operand2 = bs[0];
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || result !== ex[i-1]) begin
        n_fail++; $display("[TB] FAIL b2b_%0d got valid=%b result=%h want valid=1 result=%h", i-1, out_valid, result, ex[i-1]);
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_%0d got %b want 1", i-1, in_ready); end
      if (i < 3) begin
        operation = ops[i]; operand1 = as[i]; operand2 = bs[i];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r, er; logic [3:0] f, ef; logic e, ee, br; int lat, el;
    run_op(4'd11, '1, 64'd2, r, f, e, lat, br);
    n_checks++; if (r !== 64'd1) begin n_fail++; $display("[TB] FAIL mulhu_result got %h want 1", r); end
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("[TB] FAIL mulhu_latency got %0d want %0d", lat, W + 1); end
    n_checks++; if (br !== 1'b0) begin n_fail++; $display("[TB] FAIL mulhu_in_ready_busy got %b want 0", br); end
    run_op(4'd10, '1, 64'd2, r, f, e, lat, br);
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("[TB] FAIL mul_result got %h want fffffffffffffffe", r); end
    n_checks++; if (f !== 4'b0010 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_flag got %b err %b want 0010 err 0", f, e); end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] op; logic [W-1:0] a, b;
      op = (i % 2 == 0) ? 4'd10 : 4'd11;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      model(op, a, b, er, ef, ee, el);
      run_op(op, a, b, r, f, e, lat, br);
      n_checks++; if (r !== er || f !== ef || lat !== el) begin
        n_fail++; $display("[TB] FAIL mul_rand op=%0d got r=%h f=%b lat=%0d want r=%h f=%b lat=%0d", op, r, f, lat, er, ef, el);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    operation = 4'd3; operand1 = 64'hA5A5_0000_0000_0000; operand2 = 64'h0000_0000_0000_0F0F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; operand1 = '0; operand2 = '0; operation = 4'd0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1 || result !== 64'hA5A5_0000_0000_0F0F || flag !== 4'b0010 || in_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL backpressure_hold_%0d got valid=%b r=%h f=%b rdy=%b want valid=1 r=a5a5000000000f0f f=0010 rdy=0",
                           i, out_valid, result, flag, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL backpressure_release got %b want 1", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL backpressure_drain got %b want 0", out_valid); end
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic [3:0] f; logic e, br; int lat;
`ifdef ULA_DIV_EN
    run_op(4'd12, 64'd100, 64'd7, r, f, e, lat, br);
    n_checks++; if (r !== 64'd14 || lat !== W + 1) begin n_fail++; $display("[TB] FAIL divu got %0d lat %0d want 14 lat %0d", r, lat, W + 1); end
    run_op(4'd13, 64'd100, 64'd7, r, f, e, lat, br);
    n_checks++; if (r !== 64'd2) begin n_fail++; $display("[TB] FAIL remu got %0d want 2", r); end
    run_op(4'd12, 64'h1234_5678, 64'd0, r, f, e, lat, br);
    n_checks++; if (r !== '1 || f !== 4'b0010 || e !== 1'b0 || lat !== W + 1) begin
      n_fail++; $display("[TB] FAIL divu_by_zero got r=%h f=%b e=%b lat=%0d want all ones f=0010 e=0 lat=%0d", r, f, e, lat, W + 1);
    end
    run_op(4'd13, 64'h1234_5678, 64'd0, r, f, e, lat, br);
    n_checks++; if (r !== 64'h1234_5678) begin n_fail++; $display("[TB] FAIL remu_by_zero got %h want 12345678", r); end
`else
    run_op(4'd12, 64'd100, 64'd7, r, f, e, lat, br);
    n_checks++; if (r !== '0 || e !== 1'b1 || f !== 4'b0001 || lat !== 1) begin
      n_fail++; $display("[TB] FAIL divu_disabled got r=%h e=%b f=%b lat=%0d want 0 e=1 f=0001 lat=1", r, e, f, lat);
    end
`endif
    run_op(4'd15, 64'd3, 64'd4, r, f, e, lat, br);
    n_checks++; if (r !== '0 || e !== 1'b1 || f !== 4'b0001 || lat !== 1) begin
      n_fail++; $display("[TB] FAIL reserved_op got r=%h e=%b f=%b lat=%0d want 0 e=1 f=0001 lat=1", r, e, f, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r, er, a, b; logic [3:0] f, ef, op; logic e, ee, br; int lat, el, mode;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (mode == 1) begin a = W'($urandom_range(0, 20)); b = W'($urandom_range(0, 20)); end
      if (mode == 2) b = '0;
      if (mode == 3) b = a;
      model(op, a, b, er, ef, ee, el);
      run_op(op, a, b, r, f, e, lat, br);
      n_checks++; if (r !== er || f !== ef || e !== ee || lat !== el) begin
        n_fail++; $display("[TB] FAIL random_%0d op=%0d a=%h b=%h got r=%h f=%b e=%b lat=%0d want r=%h f=%b e=%b lat=%0d",
                           i, op, a, b, r, f, e, lat, er, ef, ee, el);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r; logic [3:0] f; logic e, br, late; int lat;
    run_op(4'd0, 64'd1, 64'd1, r, f, e, lat, br);
    @(negedge clk);
    operation = 4'd10; operand1 = 64'd3; operand2 = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || result !== '0) begin
      n_fail++; $display("[TB] FAIL reset_mid_mul_async got valid=%b r=%h want valid=0 r=0", out_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_mid_mul_after got valid=%b r=%h rdy=%b want 0 0 1", out_valid, result, in_ready);
    end
    late = 1'b0;
    repeat (W + 10) begin
      @(negedge clk);
      if (out_valid) late = 1'b1;
    end
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_mul_late got %b want 0", late); end
  endtask

  initial begin
    $display("[TB] starting ula_multiciclo bench");
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_div();
    test_random();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
